// File: rtl/multiexp_fpn_seq_if.sv
// Word stream interface shared by the multi-exponentiation sequencer ports.
//   val/rdy : handshake, a word moves on a clock edge where both are high
//   dat     : one field element per word
//   ctl     : side-band control, echoed from the request burst
//   sop/eop : first / last word of a burst
// master drives the stream, slave accepts it.
interface if_axi_stream #(
  parameter int unsigned DAT_BITS = 381,
  parameter int unsigned CTL_BITS = 16
) ();
  logic                val;
  logic                rdy;
  logic [DAT_BITS-1:0] dat;
  logic [CTL_BITS-1:0] ctl;
  logic                sop;
  logic                eop;

  modport master (output val, dat, ctl, sop, eop, input rdy);
  modport slave  (input val, dat, ctl, sop, eop, output rdy);
endinterface

// File: rtl/multiexp_fpn_seq.sv
// Multi-exponentiation sequencer for Jacobian EC points over Fp / Fp^k.
// Deserialises a looping stream of {scalar, point} bursts, runs MSB-first
// double-and-add over all scalar bits using external add / double units,
// then serialises the single result point.
// Ports:
//   i_clk, i_rst       : clock, synchronous active-high reset
//   i_pnt_scl_if       : input bursts, 1 scalar word + 3*N_WORDS point words
//   o_pnt_if           : result burst, 3*N_WORDS words
//   i_num_in           : pairs per pass, sampled when a job starts
//   o_add_* / i_add_*  : add request (p1 = input point, p2 = accumulator) / result
//   o_dbl_* / i_dbl_*  : double request (p = accumulator) / result
//   o_fmt_err          : sticky stream format error
//   o_busy             : job in progress
module multiexp_fpn_seq #(
  parameter int unsigned FE_BITS  = 381,
  parameter int unsigned N_WORDS  = 2,
  parameter int unsigned KEY_BITS = 256,
  parameter int unsigned CTL_BITS = 16,
  localparam int unsigned PNT_BITS = 3 * N_WORDS * FE_BITS
) (
  input  logic                i_clk,
  input  logic                i_rst,
  if_axi_stream.slave         i_pnt_scl_if,
  if_axi_stream.master        o_pnt_if,
  input  logic [63:0]         i_num_in,
  output logic                o_add_val,
  input  logic                i_add_rdy,
  output logic [PNT_BITS-1:0] o_add_p1,
  output logic [PNT_BITS-1:0] o_add_p2,
  input  logic                i_add_res_val,
  output logic                o_add_res_rdy,
  input  logic [PNT_BITS-1:0] i_add_res,
  input  logic                i_add_err,
  output logic                o_dbl_val,
  input  logic                i_dbl_rdy,
  output logic [PNT_BITS-1:0] o_dbl_p,
  input  logic                i_dbl_res_val,
  output logic                o_dbl_res_rdy,
  input  logic [PNT_BITS-1:0] i_dbl_res,
  output logic                o_fmt_err,
  output logic                o_busy
);
  localparam int unsigned PW      = 3 * N_WORDS;       // words per point
  localparam int unsigned SW      = PW + 1;            // words per input burst
  localparam int unsigned SR_BITS = SW * FE_BITS;
  localparam int unsigned CW      = $clog2(SW + 1);
  localparam int unsigned OW      = $clog2(PW + 1);
  localparam int unsigned KW      = (KEY_BITS > 1) ? $clog2(KEY_BITS) : 1;

  typedef enum logic [2:0] {
    StIdle, StFetch, StAddReq, StAddWait, StDblReq, StDblWait, StOut
  } state_e;

  // ---------------- deserialiser ----------------
  logic [SR_BITS-1:0]  sreg_q;
  logic [CW-1:0]       wcnt_q, widx, wnxt;
  logic [CTL_BITS-1:0] ctl_sop_q, pair_ctl_q;
  logic                pair_val_q, pair_take, in_acc, fmt_bad, fmt_err_q;
  logic [FE_BITS-1:0]  pair_scl;
  logic [PNT_BITS-1:0] pair_pnt;

  assign in_acc   = i_pnt_scl_if.val & i_pnt_scl_if.rdy;
  assign widx     = i_pnt_scl_if.sop ? '0 : wcnt_q;
  assign wnxt     = (widx == CW'(SW)) ? widx : widx + 1'b1;  // saturate on runaway bursts
  assign fmt_bad  = (i_pnt_scl_if.eop && (widx != CW'(PW))) ||
                    (i_pnt_scl_if.sop && (wcnt_q != '0));
  // Oldest word ends up lowest: scalar word at the bottom, then X low word.
  assign pair_scl = sreg_q[FE_BITS-1:0];
  assign pair_pnt = sreg_q[SR_BITS-1:FE_BITS];

  assign i_pnt_scl_if.rdy = ~pair_val_q | pair_take;
  assign o_fmt_err        = fmt_err_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sreg_q     <= '0;
      wcnt_q     <= '0;
      ctl_sop_q  <= '0;
      pair_ctl_q <= '0;
      pair_val_q <= 1'b0;
      fmt_err_q  <= 1'b0;
    end else begin
      if (in_acc) begin
        sreg_q <= {i_pnt_scl_if.dat, sreg_q[SR_BITS-1:FE_BITS]};
        wcnt_q <= i_pnt_scl_if.eop ? '0 : wnxt;
        if (i_pnt_scl_if.sop) ctl_sop_q <= i_pnt_scl_if.ctl;
        if (i_pnt_scl_if.eop) begin
          pair_ctl_q <= i_pnt_scl_if.sop ? i_pnt_scl_if.ctl : ctl_sop_q;
        end
        if (fmt_bad) fmt_err_q <= 1'b1;
      end
      if (in_acc && i_pnt_scl_if.eop) pair_val_q <= 1'b1;
      else if (pair_take)              pair_val_q <= 1'b0;
    end
  end

  // ---------------- sequencer ----------------
  state_e              state_q, state_d;
  logic [PNT_BITS-1:0] acc_q, acc_d, pnt_q, pnt_d, out_res;
  logic                acc_inf_q, acc_inf_d, err_dbl_q, err_dbl_d;
  logic [KW-1:0]       key_q, key_d;
  logic [63:0]         in_cnt_q, in_cnt_d, num_q, num_d;
  logic [1:0]          mode_q, mode_d, mode_new;
  logic [CTL_BITS-1:0] ctl_q, ctl_d, out_ctl_q, out_ctl_d;
  logic [OW-1:0]       out_cnt_q, out_cnt_d;
  logic [FE_BITS-1:0]  out_dat_q, out_dat_d;
  logic                out_val_q, out_val_d, out_sop_q, out_sop_d, out_eop_q, out_eop_d;
  logic                add_val_q, add_val_d, dbl_val_q, dbl_val_d, do_adv, eff_bit;

  assign out_res  = acc_inf_q ? '0 : acc_q;
  assign mode_new = (pair_ctl_q[1:0] == 2'd3) ? 2'd0 : pair_ctl_q[1:0];
  assign eff_bit  = (mode_q == 2'd1) | pair_scl[key_q];

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    acc_inf_d = acc_inf_q;
    pnt_d     = pnt_q;
    err_dbl_d = err_dbl_q;
    key_d     = key_q;
    in_cnt_d  = in_cnt_q;
    num_d     = num_q;
    mode_d    = mode_q;
    ctl_d     = ctl_q;
    out_cnt_d = (state_q == StOut) ? out_cnt_q : '0;
    out_val_d = out_val_q;
    out_dat_d = out_dat_q;
    out_sop_d = out_sop_q;
    out_eop_d = out_eop_q;
    out_ctl_d = out_ctl_q;
    pair_take = 1'b0;
    do_adv    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pair_val_q && !out_val_q) begin
          mode_d    = mode_new;
          ctl_d     = pair_ctl_q;
          acc_d     = '0;
          acc_inf_d = 1'b1;
          err_dbl_d = 1'b0;
          in_cnt_d  = '0;
          num_d     = (mode_new == 2'd2) ? 64'd1 : i_num_in;
          key_d     = (mode_new == 2'd1) ? '0 : KW'(KEY_BITS - 1);
          // The pair stays queued; FETCH consumes it.
          state_d   = ((mode_new != 2'd2) && (i_num_in == 64'd0)) ? StOut : StFetch;
        end
      end
      StFetch: begin
        if (pair_val_q) begin
          pair_take = 1'b1;
          pnt_d     = pair_pnt;
          if (!eff_bit) begin
            do_adv = 1'b1;
          end else if (acc_inf_q) begin
            acc_d     = pair_pnt;
            acc_inf_d = 1'b0;
            do_adv    = 1'b1;
          end else begin
            state_d = StAddReq;
          end
        end
      end
      StAddReq: if (add_val_q && i_add_rdy) state_d = StAddWait;
      StAddWait: begin
        if (i_add_res_val) begin
          if (i_add_err) begin
            // p1 == p2: the sum is a doubling of the accumulator.
            err_dbl_d = 1'b1;
            state_d   = StDblReq;
          end else begin
            acc_d  = i_add_res;
            do_adv = 1'b1;
          end
        end
      end
      StDblReq: if (dbl_val_q && i_dbl_rdy) state_d = StDblWait;
      StDblWait: begin
        if (i_dbl_res_val) begin
          acc_d = i_dbl_res;
          if (err_dbl_q) begin
            err_dbl_d = 1'b0;
            do_adv    = 1'b1;
          end else begin
            state_d = StFetch;
          end
        end
      end
      StOut: begin
        if (out_val_q && o_pnt_if.rdy && out_eop_q) begin
          out_val_d = 1'b0;
          state_d   = StIdle;
        end else if (!out_val_q || o_pnt_if.rdy) begin
          out_val_d = 1'b1;
          out_dat_d = out_res[int'(out_cnt_q) * FE_BITS +: FE_BITS];
          out_sop_d = (out_cnt_q == '0);
          out_eop_d = (out_cnt_q == OW'(PW - 1));
          out_ctl_d = ctl_q;
          out_cnt_d = out_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (do_adv) begin
      if (in_cnt_q + 64'd1 < num_q) begin
        in_cnt_d = in_cnt_q + 64'd1;
        state_d  = StFetch;
      end else begin
        in_cnt_d = '0;
        if (key_q == '0) begin
          state_d = StOut;
        end else begin
          key_d   = key_q - 1'b1;
          // No doubling while the accumulator is still the point at infinity.
          state_d = acc_inf_d ? StFetch : StDblReq;
        end
      end
    end

    add_val_d = (state_d == StAddReq);
    dbl_val_d = (state_d == StDblReq);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      acc_inf_q <= 1'b1;
      pnt_q     <= '0;
      err_dbl_q <= 1'b0;
      key_q     <= '0;
      in_cnt_q  <= '0;
      num_q     <= '0;
      mode_q    <= '0;
      ctl_q     <= '0;
      out_cnt_q <= '0;
      out_val_q <= 1'b0;
      out_dat_q <= '0;
      out_sop_q <= 1'b0;
      out_eop_q <= 1'b0;
      out_ctl_q <= '0;
      add_val_q <= 1'b0;
      dbl_val_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      acc_inf_q <= acc_inf_d;
      pnt_q     <= pnt_d;
      err_dbl_q <= err_dbl_d;
      key_q     <= key_d;
      in_cnt_q  <= in_cnt_d;
      num_q     <= num_d;
      mode_q    <= mode_d;
      ctl_q     <= ctl_d;
      out_cnt_q <= out_cnt_d;
      out_val_q <= out_val_d;
      out_dat_q <= out_dat_d;
      out_sop_q <= out_sop_d;
      out_eop_q <= out_eop_d;
      out_ctl_q <= out_ctl_d;
      add_val_q <= add_val_d;
      dbl_val_q <= dbl_val_d;
    end
  end

  assign o_add_val     = add_val_q;
  assign o_add_p1      = pnt_q;
  assign o_add_p2      = acc_q;
  assign o_dbl_val     = dbl_val_q;
  assign o_dbl_p       = acc_q;
  assign o_add_res_rdy = 1'b1;
  assign o_dbl_res_rdy = 1'b1;
  assign o_busy        = (state_q != StIdle);

  assign o_pnt_if.val = out_val_q;
  assign o_pnt_if.dat = out_dat_q;
  assign o_pnt_if.ctl = out_ctl_q;
  assign o_pnt_if.sop = out_sop_q;
  assign o_pnt_if.eop = out_eop_q;
endmodule

// File: tb/tb_multiexp_fpn_seq.sv
// Bench for multiexp_fpn_seq with toy-group EC stubs (point = integer in the low
// word, add = p1+p2 with err on p1==p2, dbl = 2p, 5-cycle result latency).
// All bench activity happens on the falling clock edge.
module tb_multiexp_fpn_seq;
  localparam int unsigned FE = 16;
  localparam int unsigned NW = 2;
  localparam int unsigned KB = 8;
  localparam int unsigned CB = 16;
  localparam int unsigned PB = 3 * NW * FE;

  typedef struct {
    logic [PB-1:0] pnt;
    logic [CB-1:0] ctl;
    int            n_add;
    int            n_dbl;
  } exp_t;

  logic          clk, i_rst;
  logic [63:0]   i_num_in;
  logic          o_add_val, i_add_rdy, i_add_res_val, o_add_res_rdy, i_add_err;
  logic [PB-1:0] o_add_p1, o_add_p2, i_add_res, o_dbl_p, i_dbl_res;
  logic          o_dbl_val, i_dbl_rdy, i_dbl_res_val, o_dbl_res_rdy, o_fmt_err, o_busy;

  if_axi_stream #(.DAT_BITS(FE), .CTL_BITS(CB)) in_if ();
  if_axi_stream #(.DAT_BITS(FE), .CTL_BITS(CB)) out_if ();

  multiexp_fpn_seq #(.FE_BITS(FE), .N_WORDS(NW), .KEY_BITS(KB), .CTL_BITS(CB)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_pnt_scl_if(in_if), .o_pnt_if(out_if),
    .i_num_in(i_num_in),
    .o_add_val(o_add_val), .i_add_rdy(i_add_rdy), .o_add_p1(o_add_p1), .o_add_p2(o_add_p2),
    .i_add_res_val(i_add_res_val), .o_add_res_rdy(o_add_res_rdy), .i_add_res(i_add_res),
    .i_add_err(i_add_err),
    .o_dbl_val(o_dbl_val), .i_dbl_rdy(i_dbl_rdy), .o_dbl_p(o_dbl_p),
    .i_dbl_res_val(i_dbl_res_val), .o_dbl_res_rdy(o_dbl_res_rdy), .i_dbl_res(i_dbl_res),
    .o_fmt_err(o_fmt_err), .o_busy(o_busy)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_add    = 0;
  int   n_dbl    = 0;
  logic stall    = 1'b0;
  exp_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [PB-1:0] act, input logic [PB-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [15:0] val, input logic [CB-1:0] c, input int na,
                          input int nd);
    exp_t e;
    e.pnt   = '0;
    e.pnt[15:0] = val;
    e.ctl   = c;
    e.n_add = na;
    e.n_dbl = nd;
    exp_q.push_back(e);
  endtask

  // Entered and left on a falling edge.
  task automatic send_word(input logic [FE-1:0] d, input logic [CB-1:0] c, input logic s,
                           input logic e);
    if (stall) while ($urandom_range(0, 2) == 0) @(negedge clk);
    in_if.val = 1'b1;
    in_if.dat = d;
    in_if.ctl = c;
    in_if.sop = s;
    in_if.eop = e;
    while (!in_if.rdy) @(negedge clk);
    @(negedge clk);
    in_if.val = 1'b0;
  endtask

  task automatic send_pair(input logic [FE-1:0] scl, input logic [FE-1:0] pt,
                           input logic [CB-1:0] c);
    for (int w = 0; w < 7; w++) begin
      send_word((w == 0) ? scl : ((w == 1) ? pt : 16'h0), c, w == 0, w == 6);
    end
  endtask

  task automatic wait_drain();
    while (exp_q.size() != 0) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  // Add unit stub.
  initial begin
    int cnt; logic pend; logic [15:0] r; logic er;
    pend = 1'b0; cnt = 0; r = '0; er = 1'b0;
    i_add_rdy = 1'b1; i_add_res_val = 1'b0; i_add_res = '0; i_add_err = 1'b0;
    forever begin
      @(negedge clk);
      i_add_res_val = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          i_add_res_val = 1'b1;
          i_add_res     = {{(PB-16){1'b0}}, r};
          i_add_err     = er;
          pend          = 1'b0;
        end
      end
      i_add_rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!i_rst && o_add_val && i_add_rdy) begin
        pend = 1'b1; cnt = 5;
        r    = o_add_p1[15:0] + o_add_p2[15:0];
        er   = (o_add_p1 == o_add_p2);
        n_add++;
      end
    end
  end

  // Double unit stub.
  initial begin
    int cnt; logic pend; logic [15:0] r;
    pend = 1'b0; cnt = 0; r = '0;
    i_dbl_rdy = 1'b1; i_dbl_res_val = 1'b0; i_dbl_res = '0;
    forever begin
      @(negedge clk);
      i_dbl_res_val = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          i_dbl_res_val = 1'b1;
          i_dbl_res     = {{(PB-16){1'b0}}, r};
          pend          = 1'b0;
        end
      end
      i_dbl_rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!i_rst && o_dbl_val && i_dbl_rdy) begin
        pend = 1'b1; cnt = 5;
        r    = {o_dbl_p[14:0], 1'b0};
        n_dbl++;
      end
    end
  end

  // Output monitor / scoreboard.
  initial begin
    int wc; logic [PB-1:0] pt; logic frame_ok; exp_t e;
    wc = 0; pt = '0; frame_ok = 1'b1;
    out_if.rdy = 1'b1;
    forever begin
      @(negedge clk);
      out_if.rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (i_rst) begin
        wc = 0; pt = '0; frame_ok = 1'b1;
      end else if (out_if.val && out_if.rdy) begin
        if (out_if.sop != (wc == 0)) frame_ok = 1'b0;
        if (wc < 6) pt[wc*16 +: 16] = out_if.dat;
        wc++;
        if (out_if.eop) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got %0h, required no output", pt);
          end else begin
            e = exp_q.pop_front();
            check("result", pt, e.pnt);
            check("ctl", PB'(out_if.ctl), PB'(e.ctl));
            check("word_count", PB'(wc), PB'(6));
            check("sop_position", PB'(frame_ok), PB'(1));
            check("add_requests", PB'(n_add), PB'(e.n_add));
            check("dbl_requests", PB'(n_dbl), PB'(e.n_dbl));
          end
          wc = 0; pt = '0; frame_ok = 1'b1; n_add = 0; n_dbl = 0;
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_add_val"}, PB'(o_add_val), '0);
    check({tag, "_dbl_val"}, PB'(o_dbl_val), '0);
    check({tag, "_out_val"}, PB'(out_if.val), '0);
    check({tag, "_fmt_err"}, PB'(o_fmt_err), '0);
    check({tag, "_busy"}, PB'(o_busy), '0);
    check({tag, "_in_rdy"}, PB'(in_if.rdy), PB'(1));
    check({tag, "_add_p1"}, o_add_p1, '0);
    check({tag, "_add_p2"}, o_add_p2, '0);
    check({tag, "_dbl_p"}, o_dbl_p, '0);
    check({tag, "_out_fields"}, PB'({out_if.dat, out_if.ctl, out_if.sop, out_if.eop}), '0);
  endtask

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: got timeout, required completion (%0d results pending)",
             exp_q.size());
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    i_rst = 1'b1; i_num_in = '0;
    in_if.val = 1'b0; in_if.dat = '0; in_if.ctl = '0; in_if.sop = 1'b0; in_if.eop = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    i_rst = 1'b0;
    @(negedge clk);

    // Mode 0: 3*7 + 5*11 = 76; first doubling only after bit 2.
    i_num_in = 64'd2;
    push_exp(16'd76, 16'h0010, 3, 2);
    repeat (KB) begin send_pair(8'd3, 16'd7, 16'h0010); send_pair(8'd5, 16'd11, 16'h0010); end

    // Mode 1: 4 + 9 + 20.
    i_num_in = 64'd3;
    push_exp(16'd33, 16'h0001, 2, 0);
    send_pair(0, 16'd4, 16'h0001); send_pair(0, 16'd9, 16'h0001); send_pair(0, 16'd20, 16'h0001);

    // Mode 2: 3 * 6.
    push_exp(16'd18, 16'h0002, 1, 1);
    repeat (KB) send_pair(8'd3, 16'd6, 16'h0002);

    // Mode 1 with equal points: add reports err, double gives 12.
    i_num_in = 64'd2;
    push_exp(16'd12, 16'h0001, 1, 1);
    send_pair(0, 16'd6, 16'h0001); send_pair(0, 16'd6, 16'h0001);

    // All-zero scalars: infinity, no EC requests.
    push_exp(16'd0, 16'h0000, 0, 0);
    repeat (KB) begin send_pair(0, 16'd7, 16'h0000); send_pair(0, 16'd9, 16'h0000); end

    // num_in = 0 (mode 3 behaves as 0): zero result, pair left queued for the next job,
    // which then runs with num_in = 1: 3 * 5 = 15.
    wait_drain();
    i_num_in = 64'd0;
    push_exp(16'd0, 16'h0013, 0, 0);
    push_exp(16'd15, 16'h0013, 1, 1);
    send_pair(8'd3, 16'd5, 16'h0013);
    while (!o_busy) @(negedge clk);
    i_num_in = 64'd1;
    repeat (KB - 1) send_pair(8'd3, 16'd5, 16'h0013);

    // Backpressure everywhere, same job as the first one.
    wait_drain();
    stall = 1'b1;
    i_num_in = 64'd2;
    push_exp(16'd76, 16'h00A4, 3, 2);
    repeat (KB) begin send_pair(8'd3, 16'd7, 16'h00A4); send_pair(8'd5, 16'd11, 16'h00A4); end
    wait_drain();
    stall = 1'b0;

    // Short burst (eop on word 3) flags a format error; the pair still starts a job.
    check("fmt_err_clear", PB'(o_fmt_err), '0);
    i_num_in = 64'd2;
    send_word(16'd1, 16'h0001, 1'b1, 1'b0);
    send_word(16'd2, 16'h0001, 1'b0, 1'b0);
    send_word(16'd3, 16'h0001, 1'b0, 1'b0);
    send_word(16'd4, 16'h0001, 1'b0, 1'b1);
    check("fmt_err_set", PB'(o_fmt_err), PB'(1));
    n_add = 0;
    send_pair(0, 16'd9, 16'h0001);
    while (n_add == 0) @(negedge clk);
    repeat (2) @(negedge clk);
    check("busy_in_add_wait", PB'(o_busy), PB'(1));
    i_rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midjob");
    i_rst = 1'b0;
    repeat (12) @(negedge clk);
    n_add = 0; n_dbl = 0;

    // Clean job after reset: 5 * 3 = 15.
    push_exp(16'd15, 16'h0002, 1, 2);
    repeat (KB) send_pair(8'd5, 16'd3, 16'h0002);
    wait_drain();
    repeat (10) @(negedge clk);
    check("pending_results", PB'(exp_q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
